// File: rtl/vx_tcu_drl_max_exp_pipe.sv
// Elastic two-stage max-exponent reducer for the TCU DRL FEDP datapath.
// Tracks a running maximum across multi-beat groups and emits per-lane and accumulator shifts.
module vx_tcu_drl_max_exp_pipe #(
    parameter int NL      = 9,
    parameter int EXP_W   = 10,
    parameter int SHIFT_W = 8,
    parameter int ID_W    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    output logic                  ready_in,
    input  logic [ID_W-1:0]       req_id_in,
    input  logic                  last_in,
    input  logic [NL*EXP_W-1:0]   exps_in,
    input  logic [NL-1:0]         lane_vld_in,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic [ID_W-1:0]       req_id_out,
    output logic                  last_out,
    output logic [EXP_W-1:0]      max_exp,
    output logic [NL*SHIFT_W-1:0] shift_amt,
    output logic [SHIFT_W-1:0]    acc_shift,
    output logic                  group_first
);

    localparam int SHIFT_MAX = (1 << SHIFT_W) - 1;

    function automatic logic [SHIFT_W-1:0] sat(input logic [EXP_W-1:0] d);
        if (32'(d) > SHIFT_MAX)
            return SHIFT_W'(SHIFT_MAX);
        else
            return d[SHIFT_W-1:0];
    endfunction

    logic                  r_s1_valid;
    logic [EXP_W-1:0]      r_s1_max;
    logic [NL*EXP_W-1:0]   r_s1_exps;
    logic [NL-1:0]         r_s1_mask;
    logic [ID_W-1:0]       r_s1_id;
    logic                  r_s1_last;

    logic                  r_valid_out;
    logic [EXP_W-1:0]      r_run_max;
    logic                  r_grp_start;
    logic [NL*SHIFT_W-1:0] r_shift;
    logic [SHIFT_W-1:0]    r_acc_shift;
    logic                  r_group_first;
    logic                  r_last_out;
    logic [ID_W-1:0]       r_id_out;

    logic                  w_advance;
    logic [EXP_W-1:0]      w_beat_max;
    logic [EXP_W-1:0]      w_new_max;
    logic [SHIFT_W-1:0]    w_acc_shift;
    logic [NL*SHIFT_W-1:0] w_shift;

    assign w_advance = !r_valid_out || ready_out;
    assign ready_in  = w_advance || !r_s1_valid;

    // Masked lanes contribute 0, so an all-masked beat reduces to 0.
    always_comb begin
        w_beat_max = '0;
        for (int i = 0; i < NL; i++) begin
            if (lane_vld_in[i] && (exps_in[i*EXP_W +: EXP_W] > w_beat_max))
                w_beat_max = exps_in[i*EXP_W +: EXP_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_max   <= '0;
            r_s1_exps  <= '0;
            r_s1_mask  <= '0;
            r_s1_id    <= '0;
            r_s1_last  <= 1'b0;
        end else if (ready_in) begin
            r_s1_valid <= valid_in;
            if (valid_in) begin
                r_s1_max  <= w_beat_max;
                r_s1_exps <= exps_in;
                r_s1_mask <= lane_vld_in;
                r_s1_id   <= req_id_in;
                r_s1_last <= last_in;
            end
        end
    end

    // A group opener ignores the stale running max from the previous group.
    assign w_new_max   = (r_grp_start || (r_s1_max > r_run_max)) ? r_s1_max : r_run_max;
    assign w_acc_shift = r_grp_start ? '0 : sat(w_new_max - r_run_max);

    generate
        for (genvar gi = 0; gi < NL; gi++) begin : g_lane_shift
            assign w_shift[gi*SHIFT_W +: SHIFT_W] = r_s1_mask[gi]
                ? sat(w_new_max - r_s1_exps[gi*EXP_W +: EXP_W])
                : SHIFT_W'(SHIFT_MAX);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid_out   <= 1'b0;
            r_run_max     <= '0;
            r_grp_start   <= 1'b1;
            r_shift       <= '0;
            r_acc_shift   <= '0;
            r_group_first <= 1'b0;
            r_last_out    <= 1'b0;
            r_id_out      <= '0;
        end else if (w_advance) begin
            r_valid_out <= r_s1_valid;
            if (r_s1_valid) begin
                r_run_max     <= w_new_max;
                r_grp_start   <= r_s1_last;
                r_shift       <= w_shift;
                r_acc_shift   <= w_acc_shift;
                r_group_first <= r_grp_start;
                r_last_out    <= r_s1_last;
                r_id_out      <= r_s1_id;
            end
        end
    end

    // The reported max is always the running max after the latest beat.
    assign valid_out   = r_valid_out;
    assign max_exp     = r_run_max;
    assign shift_amt   = r_shift;
    assign acc_shift   = r_acc_shift;
    assign group_first = r_group_first;
    assign last_out    = r_last_out;
    assign req_id_out  = r_id_out;

endmodule

// File: tb/tb_vx_tcu_drl_max_exp_pipe.sv
// Directed bench for vx_tcu_drl_max_exp_pipe: table of beats with hand-computed results,
// plus back-pressure and asynchronous-reset sequences.
module tb_vx_tcu_drl_max_exp_pipe;

    localparam int NL = 4;
    localparam int EXP_W = 10;
    localparam int SHIFT_W = 8;
    localparam int ID_W = 32;

    logic                  clk;
    logic                  reset;
    logic                  valid_in;
    logic                  ready_in;
    logic [ID_W-1:0]       req_id_in;
    logic                  last_in;
    logic [NL*EXP_W-1:0]   exps_in;
    logic [NL-1:0]         lane_vld_in;
    logic                  valid_out;
    logic                  ready_out;
    logic [ID_W-1:0]       req_id_out;
    logic                  last_out;
    logic [EXP_W-1:0]      max_exp;
    logic [NL*SHIFT_W-1:0] shift_amt;
    logic [SHIFT_W-1:0]    acc_shift;
    logic                  group_first;

    vx_tcu_drl_max_exp_pipe #(
        .NL(NL), .EXP_W(EXP_W), .SHIFT_W(SHIFT_W), .ID_W(ID_W)
    ) dut (
        .clk(clk), .reset(reset),
        .valid_in(valid_in), .ready_in(ready_in),
        .req_id_in(req_id_in), .last_in(last_in),
        .exps_in(exps_in), .lane_vld_in(lane_vld_in),
        .valid_out(valid_out), .ready_out(ready_out),
        .req_id_out(req_id_out), .last_out(last_out),
        .max_exp(max_exp), .shift_amt(shift_amt),
        .acc_shift(acc_shift), .group_first(group_first)
    );

    typedef struct {
        logic [3:0][9:0] exps;
        logic [3:0]      mask;
        logic            last;
        logic [31:0]     id;
        logic [9:0]      emax;
        logic [3:0][7:0] eshift;
        logic [7:0]      eacc;
        logic            egf;
    } vec_t;

    vec_t tbl[13];
    vec_t exp_q[$];
    vec_t v;

    int checks = 0;
    int failures = 0;
    int n_acc = 0;
    int n_out = 0;
    int s1_occ;
    bit mon_en = 0;
    bit exp_ready;
    logic [31:0] next_id = 32'hA000_0000;
    bit pat[6] = '{1, 0, 0, 1, 0, 1};

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int e0, input int e1, input int e2, input int e3,
                                input logic [3:0] m, input logic l, input int mx,
                                input int s0, input int s1, input int s2, input int s3,
                                input int acc, input logic gf);
        vec_t r;
        r.exps[0] = 10'(e0); r.exps[1] = 10'(e1); r.exps[2] = 10'(e2); r.exps[3] = 10'(e3);
        r.mask = m; r.last = l; r.id = 32'h0; r.emax = 10'(mx);
        r.eshift[0] = 8'(s0); r.eshift[1] = 8'(s1); r.eshift[2] = 8'(s2); r.eshift[3] = 8'(s3);
        r.eacc = 8'(acc); r.egf = gf;
        return r;
    endfunction

    // Handshake bookkeeping: beats accepted and beats delivered since reset.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            n_acc <= 0;
            n_out <= 0;
        end else begin
            if (valid_in && ready_in) n_acc <= n_acc + 1;
            if (valid_out && ready_out) n_out <= n_out + 1;
        end
    end

    // Output scoreboard: every presented beat must equal the head of the expected queue.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (valid_out) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat id=%h required=no_beat", req_id_out);
                end else begin
                    if ({req_id_out, last_out, group_first, max_exp, acc_shift, shift_amt} !==
                        {exp_q[0].id, exp_q[0].last, exp_q[0].egf, exp_q[0].emax, exp_q[0].eacc, exp_q[0].eshift}) begin
                        failures++;
                        $display("FAIL beat id=%h got last=%0b gf=%0b max=%0d acc=%0d shift=%h required id=%h last=%0b gf=%0b max=%0d acc=%0d shift=%h",
                                 req_id_out, last_out, group_first, max_exp, acc_shift, shift_amt,
                                 exp_q[0].id, exp_q[0].last, exp_q[0].egf, exp_q[0].emax, exp_q[0].eacc, exp_q[0].eshift);
                    end else begin
                        $display("beat id=%h max=%0d acc=%0d shift=%h gf=%0b last=%0b ready_out=%0b",
                                 req_id_out, max_exp, acc_shift, shift_amt, group_first, last_out, ready_out);
                    end
                    if (ready_out) exp_q.delete(0);
                end
            end
            s1_occ = n_acc - n_out - (valid_out ? 1 : 0);
            exp_ready = !(valid_out && !ready_out && (s1_occ > 0));
            checks++;
            if (ready_in !== exp_ready) begin
                failures++;
                $display("FAIL ready_in got=%0b required=%0b (s1_occ=%0d)", ready_in, exp_ready, s1_occ);
            end
        end
    end

    task automatic send(input vec_t b, input bit push);
        bit acc;
        int guard;
        b.id = next_id;
        next_id = next_id + 1;
        valid_in = 1;
        exps_in = b.exps;
        lane_vld_in = b.mask;
        last_in = b.last;
        req_id_in = b.id;
        if (push) exp_q.push_back(b);
        acc = 0;
        guard = 0;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = ready_in;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout id=%h ready_in got=0 required=1", b.id);
        end
        valid_in = 0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending got=%0d required=0", exp_q.size());
        end
    endtask

    task automatic check1(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end else begin
            $display("check %s = %h", name, got);
        end
    endtask

    initial begin
        tbl[0]  = mk(100, 120, 90, 120, 4'b1111, 1, 120, 20, 0, 30, 0, 0, 1);
        tbl[1]  = mk(500, 10, 20, 30, 4'b1110, 0, 30, 255, 20, 10, 0, 0, 1);
        tbl[2]  = mk(7, 7, 7, 7, 4'b0000, 0, 30, 255, 255, 255, 255, 0, 0);
        tbl[3]  = mk(1, 2, 3, 4, 4'b1111, 1, 30, 29, 28, 27, 26, 0, 0);
        tbl[4]  = mk(50, 40, 30, 20, 4'b1111, 0, 50, 0, 10, 20, 30, 0, 1);
        tbl[5]  = mk(80, 79, 0, 60, 4'b1111, 0, 80, 0, 1, 80, 20, 30, 0);
        tbl[6]  = mk(60, 60, 60, 60, 4'b1111, 1, 80, 20, 20, 20, 20, 0, 0);
        tbl[7]  = mk(10, 5, 10, 0, 4'b1111, 1, 10, 0, 5, 0, 10, 0, 1);
        tbl[8]  = mk(1000, 0, 700, 744, 4'b1111, 1, 1000, 0, 255, 255, 255, 0, 1);
        tbl[9]  = mk(5, 5, 5, 5, 4'b1111, 0, 5, 0, 0, 0, 0, 0, 1);
        tbl[10] = mk(900, 5, 0, 645, 4'b1111, 1, 900, 0, 255, 255, 255, 255, 0);
        tbl[11] = mk(3, 4, 5, 6, 4'b0000, 1, 0, 255, 255, 255, 255, 0, 1);
        tbl[12] = mk(0, 0, 0, 0, 4'b1111, 1, 0, 0, 0, 0, 0, 0, 1);

        reset = 1; valid_in = 0; ready_out = 1; req_id_in = '0;
        last_in = 0; exps_in = '0; lane_vld_in = '0;
        #1;
        check1("reset_outputs",
               64'({valid_out, ready_in, last_out, group_first, max_exp, acc_shift, shift_amt}),
               64'({1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 8'd0, 32'd0}));
        check1("reset_req_id", 64'(req_id_out), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        mon_en = 1;

        // Latency: output appears two cycles after acceptance.
        send(tbl[0], 1);
        check1("latency_t1_valid_out", 64'(valid_out), 64'd0);
        @(posedge clk);
        #1;
        check1("latency_t2_valid_out", 64'(valid_out), 64'd1);

        for (int i = 1; i < 13; i++) send(tbl[i], 1);
        drain();

        // Back-pressure: replay six beats under a toggling ready_out.
        fork
            begin
                for (int k = 0; k < 6; k++) send(tbl[4 + k], 1);
            end
            begin
                int c;
                c = 0;
                while ((exp_q.size() != 0 || c < 6) && c < 200) begin
                    ready_out = pat[c % 6];
                    @(posedge clk);
                    #1;
                    c++;
                end
                ready_out = 1;
            end
        join
        drain();

        // Asynchronous reset mid-group while the output is stalled.
        mon_en = 0;
        ready_out = 0;
        send(tbl[5], 0);
        send(tbl[3], 0);
        @(posedge clk);
        #3;
        check1("stalled_valid_out", 64'(valid_out), 64'd1);
        reset = 1;
        #1;
        check1("async_reset_valid_out", 64'(valid_out), 64'd0);
        check1("async_reset_max_exp", 64'(max_exp), 64'd0);
        check1("async_reset_ready_in", 64'(ready_in), 64'd1);
        exp_q.delete();
        #2;
        reset = 0;
        @(posedge clk);
        #1;
        ready_out = 1;
        mon_en = 1;
        v = tbl[5];
        v.eacc = 8'd0;
        v.egf = 1'b1;
        send(v, 1);
        send(tbl[6], 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
